instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Pipelined RV32I instruction encoder, the inverse of the immediate decoder.
- Accepts a format tag, register/funct fields and a 32-bit signed immediate. Range-checks the immediate, scatters its bits into the format's instruction fields and emits the 32-bit word with an incrementing instruction-memory write address.
- Used by the boot/self-test loader and testbenches to build programs in hardware.
- Round-trip requirement: for any legal input, the immediate decoder's field for that format, applied to out_instr, returns in_imm.

Parameters:
- BASE_ADDR, 32'h0000_0000, address assigned to the first emitted word after reset or start.
- ADDR_W, 32, width of out_addr.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  synchronous restart pulse: flush pipeline, reload address, clear counters
- in_valid  input  1  input word valid
- in_ready  output  1  encoder can accept input this cycle
- in_fmt  input  3  format: R=0, I=1, S=2, B=3, U=4, J=5; 6–7 illegal
- in_opcode  input  7  opcode field
- in_rd  input  5  rd field
- in_rs1  input  5  rs1 field
- in_rs2  input  5  rs2 field
- in_funct3  input  3  funct3 field
- in_funct7  input  7  funct7 field (R only)
- in_imm  input  32  signed immediate (byte offset for B/J; full value for U)
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  imem address for out_instr
- out_err  output  1  this word failed its range check
- err_seen  output  1  sticky: any errored word has been emitted since reset/start
- word_count  output  16  handshaked output words since reset/start; wraps at 16'hFFFF→0

Behaviour:
- Reset (rst_n low, asynchronous): all valids 0, out_instr 0, out_addr BASE_ADDR, out_err 0, err_seen 0, word_count 0, in_ready 0 while reset is asserted.
- Two-stage valid/ready pipeline.
  - S1 registers fields and computes the range-check error.
  - S2 packs the fields into out_instr.
  - Latency: 2 cycles from input handshake to out_valid when there is no stall. Throughput: 1 word/cycle.
- Per-stage ready: ready_k = !valid_k || ready_(k+1).
  - in_ready = ready_1 && !start.
  - Output registers hold stable while out_valid && !out_ready.
  - No combinational path from out_ready to in_ready beyond this chain.
- Packing, for immediate bits [h:l]:
  - R: funct7|rs2|rs1|funct3|rd|opcode; in_imm ignored.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range check. An error is raised when:
  - I or S: in_imm is outside −2048..2047.
  - B: in_imm is outside −4096..4094, or in_imm[0] = 1.
  - J: in_imm is outside −1048576..1048574, or in_imm[0] = 1.
  - U: in_imm[11:0] ≠ 0.
  - in_fmt is 6 or 7.
  - R never raises an error.
- Errored words: out_instr = 32'h0000_0000 (illegal instruction) and out_err = 1. The word still consumes an address and a count.
- On each output handshake: out_addr advances by 4 (wraps modulo 2^ADDR_W), word_count increments, and err_seen sets if out_err = 1.
- start:
  - Next edge: valid_1 and valid_2 cleared, out_addr = BASE_ADDR, word_count = 0, err_seen = 0.
  - A simultaneous output handshake is discarded; counters are not incremented.
  - A simultaneous in_valid is not accepted.
- Reset mid-stall: in-flight words are lost; no output is produced after rst_n rises until new input arrives.

Decomposition:
- Shared package (enc_pkg):
  - fmt_e enum.
  - Opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_REG.
  - Range limit localparams.
  - Packed struct enc_req_t holding the input fields.
- Sub-module: enc_pack, purely combinational, fields + fmt → instr. Instantiated in S2; reusable by testbenches as a golden model.

Test Plan:
- I, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 → out_instr 32'h00500093, out_addr BASE_ADDR, out_err 0, out_valid exactly 2 cycles after accept.
- B, opcode 0x63, rs1=rs2=0, f3=0, imm=−4 → 32'hFE000EE3. J, opcode 0x6F, rd=1, imm=2048 → 32'h001000EF. U, opcode 0x37, rd=5, imm=32'h12345000 → 32'h123452B7.
- I with imm=2048, B with imm=3, U with imm=32'h00000001 → each gives out_instr 0 and out_err 1; err_seen rises at the first handshake; addresses advance +4 each.
- Back-to-back 8 inputs with out_ready low for cycles 3–6:
  - in_ready drops once both stages are full.
  - No word is lost or duplicated; addresses BASE..BASE+28 appear in order.
  - out_instr stays stable during the stall.
- start asserted with in_valid high and a stalled output present → in_ready 0 that cycle; next cycle out_valid 0, out_addr BASE_ADDR, word_count 0, err_seen 0.
- rst_n pulsed low asynchronously mid-stream, between clock edges → outputs reach reset values immediately, with no further out_valid until new input.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types, opcode constants and immediate range limits for the RV32I instruction encoder.
package enc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned FMT_W   = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    // fmt is kept as raw bits so the illegal codes 6 and 7 are representable
    typedef struct packed {
        logic [FMT_W-1:0]   fmt;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [INSTR_W-1:0] imm;
    } enc_req_t;

    function automatic logic range_err(enc_req_t req);
        int  v;
        logic err;
        v   = int'($signed(req.imm));
        err = 1'b0;
        case (req.fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = (v < IMM12_MIN) || (v > IMM12_MAX);
            FMT_B:        err = (v < IMM13_MIN) || (v > IMM13_MAX) || req.imm[0];
            FMT_U:        err = |req.imm[11:0];
            FMT_J:        err = (v < IMM21_MIN) || (v > IMM21_MAX) || req.imm[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/enc_pack.sv
// Combinational field packer: scatters register/funct fields and immediate bits into an RV32I word.
module enc_pack
    import enc_pkg::*;
(
    input  enc_req_t             req,
    output logic [INSTR_W-1:0]   instr
);

    logic [INSTR_W-1:0] imm;
    logic               unused_imm_lsb;

    assign imm            = req.imm;
    assign unused_imm_lsb = imm[0];

    always_comb begin
        instr = '0;
        case (req.fmt)
            FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I: instr = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            FMT_S: instr = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
            FMT_B: instr = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                            imm[4:1], imm[11], req.opcode};
            FMT_U: instr = {imm[31:12], req.rd, req.opcode};
            FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
            default: instr = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I encoder: S1 registers fields and range-checks, S2 packs and addresses.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic                 err_seen,
    output logic [15:0]          word_count
);

    enc_req_t           in_req;
    enc_req_t           s1_req;
    logic               s1_valid;
    logic               s1_err;
    logic               live;
    logic               ready_1;
    logic               ready_2;
    logic               in_fire;
    logic               out_fire;
    logic [INSTR_W-1:0] packed_instr;

    assign in_req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    // live is cleared asynchronously so in_ready is low for the whole reset assertion
    assign ready_2  = !out_valid || out_ready;
    assign ready_1  = !s1_valid || ready_2;
    assign in_ready = ready_1 && !start && live;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    enc_pack u_pack (
        .req   (s1_req),
        .instr (packed_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            s1_valid   <= 1'b0;
            s1_req     <= '0;
            s1_err     <= 1'b0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            out_addr   <= BASE_ADDR;
            err_seen   <= 1'b0;
            word_count <= '0;
        end else begin
            live <= 1'b1;
            if (start) begin
                s1_valid   <= 1'b0;
                out_valid  <= 1'b0;
                out_addr   <= BASE_ADDR;
                err_seen   <= 1'b0;
                word_count <= '0;
            end else begin
                if (ready_1) begin
                    s1_valid <= in_fire;
                    if (in_fire) begin
                        s1_req <= in_req;
                        s1_err <= range_err(in_req);
                    end
                end
                if (ready_2) begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_instr <= s1_err ? '0 : packed_instr;
                        out_err   <= s1_err;
                    end
                end
                // Errored words still consume an address slot and a count
                if (out_fire) begin
                    out_addr   <= out_addr + ADDR_W'(4);
                    word_count <= word_count + 16'd1;
                    err_seen   <= err_seen | out_err;
                end
            end
        end
    end

endmodule
